// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

   localparam logic [15:0] LOAD_BASE      = 16'h0000;
   localparam logic [15:0] MAX_WORDS      = 16'd256;
   localparam logic        CPU_RESET_INIT = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      DAT_HI,
      DAT_LO,
      WRITE,
      CHK,
      DONE,
      ERR
   } state_t;

   // States in which a stream byte may be taken.
   function automatic logic accepting(state_t s);
      return (s == HDR_HI) || (s == HDR_LO) || (s == DAT_HI) ||
             (s == DAT_LO) || (s == CHK);
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and memory write bus of the program loader.
// master = loader side, slave = stream source / memory side.
interface program_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [15:0] mem_addr;
   logic [15:0] mem_wd;
   logic        mem_we;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_addr, mem_wd, mem_we
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_addr, mem_wd, mem_we
   );
endinterface

// File: rtl/loader_word_packer.sv
// Packs accepted bytes (high byte first) into 16-bit words; with
// PROGRAM_LOADER_CHECKSUM_EN it also keeps the running XOR of payload bytes.
module loader_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load_hi,
   input  logic [7:0]  data,
   output logic [7:0]  hi_byte,
   output logic [15:0] word
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   ,
   input  logic        xor_en,
   output logic [7:0]  xor_sum
`endif
);

   logic [7:0] hi_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         hi_reg <= 8'h00;
      end else if (load_hi) begin
         hi_reg <= data;
      end
   end

   // The low byte is taken straight from the bus so the word is ready on the accepting edge.
   assign hi_byte = hi_reg;
   assign word    = {hi_reg, data};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] xor_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         xor_reg <= 8'h00;
      end else if (xor_en) begin
         xor_reg <= xor_reg ^ data;
      end
   end

   assign xor_sum = xor_reg;
`endif

endmodule

// File: rtl/program_loader.sv
// Boot loader: header count + N big-endian words from a byte stream into memory,
// holding the CPU in reset meanwhile. Optional trailing checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import program_loader_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   program_loader_if.master bus,
   output logic             cpu_reset,
   output logic             busy,
   output logic             done,
   output logic             err
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam state_t FINAL_STATE = CHK;
`else
   localparam state_t FINAL_STATE = DONE;
`endif

   state_t      state_reg, state_next;
   logic [15:0] count_reg;
   logic [15:0] idx_reg;
   logic [15:0] mem_addr_reg;
   logic [15:0] mem_wd_reg;
   logic        accept;
   logic        restart;
   logic [7:0]  hi_byte;
   logic [15:0] word;
   logic [15:0] hdr_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]  xor_sum;
`endif

   assign accept  = bus.in_valid && bus.in_ready;
   assign restart = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
   // In HDR_LO the packer's high register still holds the count high byte.
   assign hdr_count = word;

   loader_word_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .clear   (restart),
      .load_hi (accept && ((state_reg == HDR_HI) || (state_reg == DAT_HI))),
      .data    (bus.in_data),
      .hi_byte (hi_byte),
      .word    (word)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ,
      .xor_en  (accept && ((state_reg == DAT_HI) || (state_reg == DAT_LO))),
      .xor_sum (xor_sum)
`endif
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (start) state_next = HDR_HI;
         HDR_HI: if (accept) state_next = HDR_LO;
         HDR_LO: begin
            if (accept) begin
               if (hdr_count == 16'd0)           state_next = FINAL_STATE;
               else if (hdr_count > MAX_WORDS)   state_next = ERR;
               else                              state_next = DAT_HI;
            end
         end
         DAT_HI: if (accept) state_next = DAT_LO;
         DAT_LO: if (accept) state_next = WRITE;
         WRITE: begin
            if (idx_reg + 16'd1 == count_reg) state_next = FINAL_STATE;
            else                              state_next = DAT_HI;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         CHK: if (accept) state_next = (bus.in_data == xor_sum) ? DONE : ERR;
`endif
         DONE:   if (start) state_next = HDR_HI;
         ERR:    if (start) state_next = HDR_HI;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= 16'd0;
         idx_reg      <= 16'd0;
         mem_addr_reg <= LOAD_BASE;
         mem_wd_reg   <= 16'h0000;
      end else begin
         state_reg <= state_next;
         if (restart) begin
            idx_reg <= 16'd0;
         end else if (state_reg == WRITE) begin
            idx_reg <= idx_reg + 16'd1;
         end
         if (accept && (state_reg == HDR_LO)) begin
            count_reg <= hdr_count;
         end
         // Address and data are captured with the low byte so they are stable through WRITE.
         if (accept && (state_reg == DAT_LO)) begin
            mem_addr_reg <= LOAD_BASE + idx_reg;
            mem_wd_reg   <= word;
         end
      end
   end

   assign bus.in_ready = accepting(state_reg);
   assign bus.mem_we   = (state_reg == WRITE);
   assign bus.mem_addr = mem_addr_reg;
   assign bus.mem_wd   = mem_wd_reg;
   assign cpu_reset    = (state_reg == DONE) ? ~CPU_RESET_INIT : CPU_RESET_INIT;
   assign busy         = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
   assign done         = (state_reg == DONE);
   assign err          = (state_reg == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected writes come from the image itself
// (address = base + index), checked on every mem_we cycle, plus literal timing checks.
module tb_program_loader;

   logic clk = 1'b0;
   logic reset, start;
   logic cpu_reset, busy, done, err;

   program_loader_if bus ();

   program_loader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bus       (bus),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   localparam logic [15:0] BASE = 16'h0000;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] wr_log[$];
   logic [15:0] img[$];
   logic [7:0]  raw[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   // Compare process: every write must match the next expected {addr, data}.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_we) begin
            wr_log.push_back({bus.mem_addr, bus.mem_wd});
            $display("write addr=%h data=%h", bus.mem_addr, bus.mem_wd);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got %h @%h, want no write", bus.mem_wd, bus.mem_addr);
            end else begin
               check("write", {bus.mem_addr, bus.mem_wd}, exp_q.pop_front());
            end
            check("ready_in_write", bus.in_ready, 0);
            check("busy_in_write", busy, 1);
            check("cpu_reset_in_write", cpu_reset, 1);
         end
         if (done) begin
            check("done_cpu_reset", cpu_reset, 0);
            check("done_busy", busy, 0);
            check("done_ready", bus.in_ready, 0);
         end
         if (err) begin
            check("err_cpu_reset", cpu_reset, 1);
            check("err_busy", busy, 0);
            check("err_ready", bus.in_ready, 0);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (bus.in_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_accept: in_ready stayed 0 for byte %h, want 1", b);
      end
   endtask

   task automatic send_bytes(input logic [7:0] bs[$], input int max_gap);
      foreach (bs[i]) send_byte(bs[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
   endtask

   // Model: builds the stream for an image and queues the writes it must cause.
   task automatic send_stream(input logic [15:0] n, input logic [15:0] words[$], input int max_gap);
      logic [7:0] bs[$];
      logic [7:0] csum = 8'h00;
      bs.push_back(n[15:8]);
      bs.push_back(n[7:0]);
      foreach (words[i]) begin
         bs.push_back(words[i][15:8]);
         bs.push_back(words[i][7:0]);
         csum = csum ^ words[i][15:8] ^ words[i][7:0];
         exp_q.push_back({BASE + 16'(i), words[i]});
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (n <= 16'd256) bs.push_back(csum);
`endif
      send_bytes(bs, max_gap);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_ready", bus.in_ready, 1);
      check("start_busy", busy, 1);
      check("start_cpu_reset", cpu_reset, 1);
      check("start_done_clr", done, 0);
      check("start_err_clr", err, 0);
   endtask

   task automatic check_reset_vals();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 32'h0000);
      check("rst_mem_wd", bus.mem_wd, 32'h0000);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
   endtask

   // After the final stream byte of a 2-word image (last word at addr 0001 = ABCD).
   task automatic check_two_word_finish();
      @(negedge clk);
      bus.in_valid = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      check("done_after_chk", done, 1);
`else
      check("last_we", bus.mem_we, 1);
      check("last_addr", bus.mem_addr, 32'h0001);
      check("last_wd", bus.mem_wd, 32'hABCD);
      check("done_not_yet", done, 0);
      @(negedge clk);
      check("done_t2", done, 1);
      check("cpu_release_t2", cpu_reset, 0);
`endif
      check("log_size", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         check("log_w0", wr_log[0], 32'h0000_1234);
         check("log_w1", wr_log[1], 32'h0001_ABCD);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_vals();
      reset = 1'b0;

      // Basic 2-word image.
      $display("test: image 00 02 12 34 AB CD");
      img = {16'h1234, 16'hABCD};
      wr_log.delete();
      pulse_start();
      send_stream(16'd2, img, 0);
      check_two_word_finish();

      // Empty image.
      $display("test: empty image");
      img.delete();
      wr_log.delete();
      pulse_start();
      send_stream(16'd0, img, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("empty_done", done, 1);
      check("empty_no_write", wr_log.size(), 0);

      // Oversize header.
      $display("test: header 01 01");
      wr_log.delete();
      pulse_start();
      send_stream(16'h0101, img, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("big_err", err, 1);
      check("big_cpu_reset", cpu_reset, 1);
      check("big_ready", bus.in_ready, 0);
      check("big_done", done, 0);
      repeat (3) @(negedge clk);
      check("big_err_hold", err, 1);
      check("big_no_write", wr_log.size(), 0);

      // Restart from ERR with stream gaps.
      $display("test: gapped image from ERR");
      img = {16'h1234, 16'hABCD};
      wr_log.delete();
      pulse_start();
      send_stream(16'd2, img, 3);
      check_two_word_finish();

      // Reset after the first word is written.
      $display("test: reset mid-load");
      wr_log.delete();
      pulse_start();
      exp_q.push_back(32'h0000_1234);
      raw = {8'h00, 8'h02, 8'h12, 8'h34};
      send_bytes(raw, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("mid_we", bus.mem_we, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals();
      exp_q.delete();
      reset = 1'b0;
      wr_log.delete();
      pulse_start();
      send_stream(16'd2, img, 0);
      check_two_word_finish();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      $display("test: checksum good/bad/reload");
      raw = {8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
      pulse_start();
      exp_q.push_back(32'h0000_1234);
      send_bytes(raw, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("csum_good_done", done, 1);
      raw = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
      pulse_start();
      exp_q.push_back(32'h0000_1234);
      send_bytes(raw, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("csum_bad_err", err, 1);
      raw = {8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
      pulse_start();
      exp_q.push_back(32'h0000_1234);
      send_bytes(raw, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("csum_reload_done", done, 1);
`endif

      repeat (2) @(negedge clk);
      check("expected_writes_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time memory writer that is the write-side counterpart of the processor's instruction-fetch path: it receives a program as a byte stream, packs bytes into 16-bit words, and writes them into the unified memory. While loading, it holds the processor in reset and owns the memory port. When the image is complete it releases the processor to fetch from `LOAD_BASE`.

## Interface
- `LOAD_BASE`, 16'h0000, memory address of the first loaded word; also the processor's first fetch address.
- `MAX_WORDS`, 256, largest accepted image size in words; a header count above this is an error.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load; sampled in IDLE, DONE and ERR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream payload.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `mem_addr`  out  16  memory write address.
- `mem_wd`  out  16  memory write data.
- `mem_we`  out  1  memory write strobe, one cycle per word.
- `cpu_reset`  out  1  processor reset hold; when high, the top muxes the loader's bus onto the memory.
- `busy`  out  1  a load is in progress.
- `done`  out  1  image loaded; level signal.
- `err`  out  1  load aborted; level signal.

## Operation
- Stream format: count high byte, count low byte (N words), then N words. Each word is sent high byte first.
- A byte transfers on any edge where `in_valid && in_ready`.
- State sequence: IDLE → HDR_HI → HDR_LO → DAT_HI → DAT_LO → WRITE → (DAT_HI or DONE); ERR is reached on error.
- `in_ready` is high only in HDR_HI, HDR_LO, DAT_HI, DAT_LO and CHK. It is low in IDLE, WRITE, DONE and ERR.
- HDR_LO accept with N=0 → DONE.
- HDR_LO accept with N>MAX_WORDS → ERR.
- WRITE: `mem_we`=1 for exactly one cycle.
  - `mem_addr` = LOAD_BASE + word index, computed modulo 2^16 (wraps from 16'hFFFF to 16'h0000).
  - `mem_wd` = {hi, lo}.
  - The word index increments after the write.
- After the write of word N-1 → DONE.
- DONE: `done`=1, `cpu_reset`=0, `busy`=0.
- ERR: `err`=1, `cpu_reset` stays 1.
- `start` in DONE or ERR restarts the load:
  - clears `done`/`err`;
  - reasserts `cpu_reset`;
  - resets the word index.
- `start` while `busy` is ignored.
- `busy`=1 in every state except IDLE, DONE and ERR.
- Reset values:
  - `in_ready`=0, `mem_we`=0, `mem_addr`=LOAD_BASE, `mem_wd`=0;
  - `cpu_reset`=1, `busy`=0, `done`=0, `err`=0;
  - state=IDLE.
- `reset` during a load returns all outputs to their reset values next edge. Words already written stay in memory.

## Timing
- `start` at edge t → HDR_HI at t+1, so `in_ready`=1 from cycle t+1.
- Low byte accepted at edge t → `mem_we` at t+1 → `done`=1 and `cpu_reset`=0 at t+2 (last word, checksum disabled).
- Peak throughput: one word per 3 cycles.
- The stream may stall (`in_valid`=0) for any number of cycles in any accepting state without side effects.
- `mem_addr`/`mem_wd` are registered and stable for the whole WRITE cycle.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - after the last WRITE the loader enters CHK and accepts one byte;
  - the expected value is the XOR of all 2N payload bytes (header excluded);
  - match → DONE; mismatch → ERR;
  - with N=0 the expected checksum is 8'h00.
- Macro undefined: no CHK state; the last WRITE goes directly to DONE.

## Structure
- Shared package `program_loader_pkg`: state enum (IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERR) and the reset constant for `cpu_reset`.
- One sub-module, `loader_word_packer`:
  - takes accepted bytes and a hi/lo select;
  - holds the high-byte register;
  - presents the packed 16-bit word;
  - also holds the running XOR when checksum is enabled.

## Test plan
- Reset, then `start`, then stream 00 02 12 34 AB CD.
  - Expect `mem_we` pulses writing 16'h1234 @16'h0000 and 16'hABCD @16'h0001.
  - `done`=1 and `cpu_reset`=0 two cycles after byte CD is accepted.
- Header 00 00 → DONE the cycle after the low count byte; no `mem_we` ever.
- Header 01 01 (257 > MAX_WORDS) → `err`=1, `cpu_reset`=1, `in_ready`=0, no writes.
- Random `in_valid` gaps during the 2-word image → identical writes and values to the first test; `in_ready`=0 in every WRITE cycle.
- Assert `reset` after the first word is written:
  - all outputs return to reset values;
  - a new `start` plus a full stream completes normally.
- With `PROGRAM_LOADER_CHECKSUM_EN`:
  - stream 00 01 12 34 26 → DONE;
  - stream 00 01 12 34 27 → ERR.
  - A `start` pulse from ERR reloads successfully.
